// File: rtl/hh_mon_pkg.sv
// Shared constants and helpers for the hh_spike_monitor readout block:
// read-select codes, default widths and a saturating increment.
package hh_mon_pkg;

  localparam int WINDOW_CYCLES_DEF = 500;
  localparam int CNT_W_DEF         = 16;
  localparam int ISI_W_DEF         = 16;
  localparam int COINC_WIN_DEF     = 4;
  localparam int RD_W              = 16;

  localparam logic [2:0] SEL_CNT1  = 3'd0;
  localparam logic [2:0] SEL_CNT2  = 3'd1;
  localparam logic [2:0] SEL_COINC = 3'd2;
  localparam logic [2:0] SEL_LISI  = 3'd3;
  localparam logic [2:0] SEL_MISI  = 3'd4;
  localparam logic [2:0] SEL_PEAK1 = 3'd5;
  localparam logic [2:0] SEL_PEAK2 = 3'd6;
  localparam logic [2:0] SEL_WIDX  = 3'd7;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v == lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Two-stage spike synchroniser stage with a rising-edge strobe:
// rise_o is high for the one cycle where stage 1 is set and stage 2 is not.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2_q takes the old s1_q; blocking would collapse the two stages.
      s1_q <= spike_i;
      s2_q <= s1_q;
    end
  end

  assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/hh_spike_monitor.sv
// Windowed spike/coincidence/ISI/peak measurement for the HH neuron pair,
// with per-window latched results served over a one-cycle read port.
module hh_spike_monitor
  import hh_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int ISI_W         = ISI_W_DEF,
  parameter int COINC_WIN     = COINC_WIN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [7:0]      v_mem1,
  input  logic [7:0]      nrn_bus,
  input  logic            rd_req,
  input  logic [2:0]      rd_sel,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_valid,
  output logic            window_done
);

  localparam int WCNT_W = $clog2(WINDOW_CYCLES);
  localparam int AGE_W  = $clog2(COINC_WIN + 2);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [AGE_W-1:0]  AGE_LIM   = AGE_W'(COINC_WIN);
  localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(COINC_WIN + 1);

  // Input stage (S1) for the non-spike inputs
  logic       ena_q;
  logic [7:0] v1_q;
  logic [5:0] v2_q;
  logic       rd_req_q;
  logic [2:0] rd_sel_q;

  logic rise1;
  logic rise2;

  spike_edge_det u_edge1 (.clk(clk), .rst_n(rst_n), .spike_i(nrn_bus[0]), .rise_o(rise1));
  spike_edge_det u_edge2 (.clk(clk), .rst_n(rst_n), .spike_i(nrn_bus[1]), .rise_o(rise2));

  // Live measurement state
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  cnt1_q, cnt2_q, coinc_q;
  logic [7:0]        peak1_q;
  logic [5:0]        peak2_q;
  logic [AGE_W-1:0]  age1_q, age2_q;
  logic              isi_run_q;
  logic [ISI_W-1:0]  isi_tmr_q, last_isi_q, min_isi_q;
  logic [15:0]       win_idx_q;

  // Latched per-window results
  logic [CNT_W-1:0]  res_cnt1_q, res_cnt2_q, res_coinc_q;
  logic [ISI_W-1:0]  res_last_q, res_min_q;
  logic [7:0]        res_peak1_q;
  logic [5:0]        res_peak2_q;

  logic [RD_W-1:0]   rd_data_q;
  logic              rd_valid_q;
  logic              done_q;

  // Live values updated with this cycle's events, before any window clear
  logic              coinc_hit;
  logic [CNT_W-1:0]  cnt1_d, cnt2_d, coinc_d;
  logic [7:0]        peak1_d;
  logic [5:0]        peak2_d;
  logic [AGE_W-1:0]  age1_d, age2_d;
  logic              isi_run_d;
  logic [ISI_W-1:0]  isi_tmr_d, last_isi_d, min_isi_d;
  logic [RD_W-1:0]   rd_mux;

  always_comb begin
    // NOTE: every output gets a value before any branch, so no latch can be inferred.
    isi_tmr_d  = isi_tmr_q;
    last_isi_d = last_isi_q;
    min_isi_d  = min_isi_q;
    isi_run_d  = isi_run_q | rise1;

    // Only the most recent opposite edge matters: it is the closest one.
    coinc_hit = (rise1 && (rise2 || (age2_q <= AGE_LIM))) ||
                (rise2 && (age1_q <= AGE_LIM));

    cnt1_d  = rise1     ? CNT_W'(sat_inc(32'(cnt1_q),  CNT_W)) : cnt1_q;
    cnt2_d  = rise2     ? CNT_W'(sat_inc(32'(cnt2_q),  CNT_W)) : cnt2_q;
    coinc_d = coinc_hit ? CNT_W'(sat_inc(32'(coinc_q), CNT_W)) : coinc_q;

    peak1_d = (v1_q > peak1_q) ? v1_q : peak1_q;
    peak2_d = (v2_q > peak2_q) ? v2_q : peak2_q;

    age1_d = rise1 ? AGE_W'(1) : ((age1_q == AGE_MAX) ? age1_q : age1_q + AGE_W'(1));
    age2_d = rise2 ? AGE_W'(1) : ((age2_q == AGE_MAX) ? age2_q : age2_q + AGE_W'(1));

    if (rise1) begin
      isi_tmr_d = ISI_W'(1);
      if (isi_run_q) begin
        last_isi_d = isi_tmr_q;
        if (isi_tmr_q < min_isi_q) min_isi_d = isi_tmr_q;
      end
    end else if (isi_run_q) begin
      isi_tmr_d = ISI_W'(sat_inc(32'(isi_tmr_q), ISI_W));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel_q)
      SEL_CNT1:  rd_mux = RD_W'(res_cnt1_q);
      SEL_CNT2:  rd_mux = RD_W'(res_cnt2_q);
      SEL_COINC: rd_mux = RD_W'(res_coinc_q);
      SEL_LISI:  rd_mux = RD_W'(res_last_q);
      SEL_MISI:  rd_mux = RD_W'(res_min_q);
      SEL_PEAK1: rd_mux = RD_W'(res_peak1_q);
      SEL_PEAK2: rd_mux = RD_W'(res_peak2_q);
      SEL_WIDX:  rd_mux = win_idx_q;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q       <= 1'b0;
      v1_q        <= '0;
      v2_q        <= '0;
      rd_req_q    <= 1'b0;
      rd_sel_q    <= '0;
      wcnt_q      <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      coinc_q     <= '0;
      peak1_q     <= '0;
      peak2_q     <= '0;
      age1_q      <= AGE_MAX;
      age2_q      <= AGE_MAX;
      isi_run_q   <= 1'b0;
      isi_tmr_q   <= '0;
      last_isi_q  <= '0;
      min_isi_q   <= '1;
      win_idx_q   <= '0;
      res_cnt1_q  <= '0;
      res_cnt2_q  <= '0;
      res_coinc_q <= '0;
      res_last_q  <= '0;
      res_min_q   <= '1;
      res_peak1_q <= '0;
      res_peak2_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ena_q    <= ena;
      v1_q     <= v_mem1;
      v2_q     <= nrn_bus[7:2];
      rd_req_q <= rd_req;
      rd_sel_q <= rd_sel;

      // Read uses the results as they stand before this edge's latch.
      rd_valid_q <= rd_req_q;
      if (rd_req_q) rd_data_q <= rd_mux;

      done_q <= 1'b0;
      if (ena_q) begin
        age1_q     <= age1_d;
        age2_q     <= age2_d;
        isi_run_q  <= isi_run_d;
        isi_tmr_q  <= isi_tmr_d;
        last_isi_q <= last_isi_d;
        if (wcnt_q == WCNT_LAST) begin
          res_cnt1_q  <= cnt1_d;
          res_cnt2_q  <= cnt2_d;
          res_coinc_q <= coinc_d;
          res_last_q  <= last_isi_d;
          res_min_q   <= min_isi_d;
          res_peak1_q <= peak1_d;
          res_peak2_q <= peak2_d;
          cnt1_q      <= '0;
          cnt2_q      <= '0;
          coinc_q     <= '0;
          peak1_q     <= '0;
          peak2_q     <= '0;
          min_isi_q   <= '1;
          wcnt_q      <= '0;
          win_idx_q   <= win_idx_q + 16'd1;
          done_q      <= 1'b1;
        end else begin
          cnt1_q    <= cnt1_d;
          cnt2_q    <= cnt2_d;
          coinc_q   <= coinc_d;
          peak1_q   <= peak1_d;
          peak2_q   <= peak2_d;
          min_isi_q <= min_isi_d;
          wcnt_q    <= wcnt_q + WCNT_W'(1);
        end
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign window_done = done_q;

endmodule

// File: doc/hh_spike_monitor.md
# hh_spike_monitor

On-chip readout for the `tt_um_hh_stdp` neuron pair. It consumes the neuron output bus: neuron-1 membrane voltage, plus the packed `{v_mem2[5:0], spike2, spike1}` byte. Over fixed observation windows it counts spike events, coincidences, inter-spike interval (ISI) and peak voltages. It latches the per-window results and serves them through a one-cycle register read port. It is the output-side counterpart of the current-stimulus path and replaces testbench-only spike counting with synthesizable measurement.

## Interface
Parameters:
- `WINDOW_CYCLES`, 500: enabled clock cycles per observation window (10 µs at 50 MHz); must be ≥ 2.
- `CNT_W`, 16: width of the spike and coincidence counters.
- `ISI_W`, 16: width of the ISI timer and results.
- `COINC_WIN`, 4: maximum separation, in cycles, between spike1 and spike2 edges that counts as a coincidence.

Ports:
- `clk` in 1: the single system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ena` in 1: measurement enable.
- `v_mem1` in 8: neuron-1 membrane voltage (unsigned).
- `nrn_bus` in 8: `{v_mem2[5:0], spike2, spike1}`.
- `rd_req` in 1: read strobe.
- `rd_sel` in 3: result register select.
- `rd_data` out 16: read data.
- `rd_valid` out 1: read data valid.
- `window_done` out 1: one-cycle pulse when results are latched.

## Operation
- All inputs are clk-synchronous. They pass through one register stage (S1); spike lines then pass through a second stage (S2).
- A spike event is a rising edge (S1=1, S2=0). A level held high counts once.
- Window counter `wcnt` advances only while `ena`=1. With `ena`=0, every live counter, timer and peak tracker freezes, and edge detection still updates S1/S2.
- Live measurements per window:
  - cnt1 and cnt2 count spike1 and spike2 edges; both saturate at all-ones.
  - coinc counts coincidences:
    - On a spike1 edge, coinc increments if a spike2 edge occurs in the same cycle or occurred ≤ `COINC_WIN` cycles earlier.
    - On a spike2 edge, coinc increments if a spike1 edge occurred ≤ `COINC_WIN` cycles earlier.
    - Same-cycle edges count once. Coinc saturates.
  - peak1 is the maximum of `v_mem1`; peak2 is the maximum of `v_mem2`. Both are 0 at window start.
  - ISI tracking (spike1 only): the ISI timer counts enabled cycles since the last spike1 edge and saturates at all-ones.
    - The first spike1 edge after reset only starts the timer.
    - Each later spike1 edge stores the timer value into last_isi, updates min_isi, and restarts the timer at 1.
    - The timer and last_isi persist across windows. min_isi resets to all-ones at each window start.
- Window end is the enabled cycle with `wcnt`=`WINDOW_CYCLES`-1:
  - Results are latched from live values including that cycle's events.
  - Live counts and peaks clear; `wcnt` returns to 0.
  - `win_idx` (16 b) increments with wrap.
  - `window_done` pulses.
- Read map for `rd_sel`; narrower values are zero-extended:
  - 0: cnt1
  - 1: cnt2
  - 2: coinc
  - 3: last_isi
  - 4: min_isi
  - 5: peak1
  - 6: peak2 (6 b)
  - 7: win_idx
- Reads return latched results only, never live values.
- A read coinciding with a latch edge returns the pre-latch value.

## Timing
- Reset values:
  - `rd_data`=0, `rd_valid`=0, `window_done`=0.
  - All latched results 0, except latched min_isi = all-ones.
  - `wcnt`=0, `win_idx`=0, S1/S2=0.
  - The ISI timer is marked not started.
- Event path: a spike input is high at edge k → S1=1 after k → the count is updated at edge k+1.
- Window latch: `window_done` is high for exactly the cycle after the latch edge.
  - With `ena` held high from reset release, the first `window_done` rises `WINDOW_CYCLES` edges after the first enabled edge.
- Read handshake: `rd_req`=1 sampled at edge k → `rd_data`/`rd_valid` are valid after edge k+1, for one cycle.
  - Back-to-back requests are allowed at one read per cycle.
  - `rd_data` holds its last value when `rd_valid`=0.
- Reset asserted mid-window aborts all measurements immediately; nothing is latched and no `window_done` is issued.

## Structure
- Package `hh_mon_pkg` holds the `rd_sel` localparams (`SEL_CNT1`…`SEL_WIDX`), the default widths, and a saturating-increment function.
- One sub-module, `spike_edge_det`: a two-stage register with a rising-edge output. It is instantiated for spike1 and spike2.
- The top level holds the window counter, the measurement registers and the read mux.

## Test plan
- Single pulse: spike1 high for 5 cycles → read sel 0 after the window gives 1. This checks that level-held spikes count once.
- Periodic spikes: spike1 pulsed every 50 cycles, `WINDOW_CYCLES`=500 → cnt1=10, last_isi=50, min_isi=50, win_idx=1.
- Coincidence: spike2 edge 3 cycles after spike1 → coinc=1. A separation of 5 cycles → coinc=0. Simultaneous edges → coinc=1.
- Peaks: `v_mem1` ramps 0→0xC8, `nrn_bus[7:2]` reaches 0x2A → peak1=0xC8, peak2=0x2A. The next quiet window reads 0.
- `ena` low for 100 cycles mid-window → `window_done` is delayed by exactly 100 cycles and counts are unchanged across the gap.
- `rst_n` pulsed mid-window with 7 spikes counted → all reads return 0 (min_isi returns 0xFFFF), and no `window_done` is issued until `WINDOW_CYCLES` cycles after release.
